// File: rtl/dm_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU M-stage and a DMA engine.
// The policy is round-robin with a bounded DMA burst, and grants are combinational with zero added latency.
module dm_port_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_byteen,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata
);

  localparam logic [31:0]      DM_LIMIT  = 32'h0000_3000;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic             r_last;
  logic [CNT_W-1:0] r_burst_cnt;

  logic w_dma_wins;
  logic w_grant_dma;
  logic w_grant_cpu;
  logic w_dma_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= BURST_MAX) ? BURST_MAX : v + CNT_W'(1);
  endfunction

  // Grants are qualified by reset, so every output falls back to the idle or stalled state while reset is held.
  assign w_dma_wins  = ~r_last | (r_burst_cnt < BURST_MAX);
  assign w_grant_dma = reset & dma_req & (~cpu_req | w_dma_wins);
  assign w_grant_cpu = reset & cpu_req & ~w_grant_dma;
  assign w_dma_err   = w_grant_dma & (dma_addr >= DM_LIMIT);

  assign cpu_stall = cpu_req & ~w_grant_cpu;
  assign dma_ack   = w_grant_dma;
  assign dma_err   = w_dma_err;

  always_comb begin
    m_data_addr   = '0;
    m_data_wdata  = '0;
    m_data_byteen = '0;
    cpu_rdata     = '0;
    dma_rdata     = '0;
    if (w_grant_cpu) begin
      m_data_addr   = cpu_addr;
      m_data_wdata  = cpu_wdata;
      m_data_byteen = cpu_byteen;
      cpu_rdata     = m_data_rdata;
    end else if (w_grant_dma) begin
      m_data_addr  = {dma_addr[31:2], 2'b00};
      m_data_wdata = dma_wdata;
      if (!w_dma_err) begin
        m_data_byteen = dma_we ? dma_byteen : 4'b0000;
        dma_rdata     = m_data_rdata;
      end
    end
  end

  // Reset primes the state as though the DMA has already used a full burst, so the CPU wins first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last      <= 1'b1;
      r_burst_cnt <= BURST_MAX;
    end else if (w_grant_cpu) begin
      r_last      <= 1'b0;
      r_burst_cnt <= '0;
    end else if (w_grant_dma) begin
      r_last      <= 1'b1;
      r_burst_cnt <= sat_inc(r_burst_cnt);
    end else begin
      r_burst_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: directed stimulus pushes expectations into a scoreboard queue,
// and a negedge monitor drains the queue against the DUT outputs and a behavioural DM.
module tb_dm_port_arbiter;

  logic        clk = 1'b1;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_byteen;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        dma_err;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic        dm_clr;

  always #5 clk = ~clk;

  dm_port_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_byteen(dma_byteen), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_data_rdata(m_data_rdata)
  );

  // Behavioural data memory: combinational read, byte-enabled write, bulk clear.
  logic [31:0] mem [0:8191];
  assign m_data_rdata = mem[m_data_addr[14:2]];
  always @(posedge clk) begin
    if (dm_clr) begin
      for (int i = 0; i < 8192; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (m_data_byteen[b]) mem[m_data_addr[14:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end
  end

  typedef struct {
    bit          is_mem;
    int          widx;
    logic [31:0] mem_exp;
    string       name;
    logic [134:0] outs;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [134:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.is_mem) begin
        if (mem[e.widx] !== e.mem_exp) begin
          n_bad++;
          $display("FAIL %s: mem[%0h] actual=%h required=%h", e.name, e.widx, mem[e.widx], e.mem_exp);
        end
      end else begin
        act = {cpu_stall, dma_ack, dma_err, m_data_addr, m_data_wdata, m_data_byteen, cpu_rdata, dma_rdata};
        if (act !== e.outs) begin
          n_bad++;
          $display("FAIL %s: {stall,ack,err,addr,wdata,be,crd,drd} actual=%h required=%h",
                   e.name, act, e.outs);
        end
      end
    end
  end

  task automatic setin(input logic rst, input logic creq, input logic [31:0] caddr,
                       input logic [31:0] cwd, input logic [3:0] cbe, input logic dreq,
                       input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                       input logic [3:0] dbe);
    reset = rst;
    cpu_req = creq; cpu_addr = caddr; cpu_wdata = cwd; cpu_byteen = cbe;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_byteen = dbe;
  endtask

  task automatic cyc(input string nm, input logic stall, input logic ack, input logic err,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] crd, input logic [31:0] drd);
    exp_t e;
    e.is_mem = 1'b0; e.widx = 0; e.mem_exp = '0; e.name = nm;
    e.outs = {stall, ack, err, addr, wdata, be, crd, drd};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic memchk(input string nm, input int idx, input logic [31:0] v);
    exp_t e;
    e.is_mem = 1'b1; e.widx = idx; e.mem_exp = v; e.name = nm; e.outs = '0;
    sb.push_back(e);
  endtask

  initial begin
    dm_clr = 1'b1;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    dm_clr = 1'b0;
    setin(0, 1, 32'h200, 32'h1234_5678, 4'hF, 1, 1, 32'h4, 32'hAAAA_0004, 4'hF);
    cyc("rst_cont", 1, 0, 0, 0, 0, 0, 0, 0);

    // First contended cycle after reset goes to the CPU, the next to the DMA.
    setin(1, 1, 32'h200, 32'h1234_5678, 4'hF, 1, 1, 32'h4, 32'hAAAA_0004, 4'hF);
    cyc("first_cont_cpu", 0, 0, 0, 32'h200, 32'h1234_5678, 4'hF, 0, 0);
    setin(1, 1, 32'h7F00, 32'h55AA_55AA, 4'hF, 1, 1, 32'h4, 32'hAAAA_0004, 4'hF);
    cyc("second_cont_dma", 1, 1, 0, 32'h4, 32'hAAAA_0004, 4'hF, 0, 0);
    setin(1, 1, 32'h7F00, 32'h55AA_55AA, 4'hF, 0, 0, 0, 0, 0);
    cyc("cpu_high_store", 0, 0, 0, 32'h7F00, 32'h55AA_55AA, 4'hF, 0, 0);
    memchk("mem_cpu_store", 32'h80, 32'h1234_5678);

    for (int i = 0; i < 6; i++) begin
      setin(1, 0, 0, 0, 0, 1, 1, 32'(i * 4), 32'hD000_0000 + 32'(i), 4'hF);
      cyc("dma_stream", 0, 1, 0, 32'(i * 4), 32'hD000_0000 + 32'(i), 4'hF, 0,
          (i == 1) ? 32'hAAAA_0004 : 32'h0);
    end
    for (int i = 0; i < 6; i++) memchk("mem_dma_stream", i, 32'hD000_0000 + 32'(i));

    setin(1, 0, 0, 0, 0, 1, 1, 32'h104, 32'hDEAD_BEEF, 4'hF);
    cyc("dma_wr_104", 0, 1, 0, 32'h104, 32'hDEAD_BEEF, 4'hF, 0, 0);
    setin(1, 0, 0, 0, 0, 1, 0, 32'h106, 32'h1111_2222, 4'hF);
    cyc("dma_rd_104", 0, 1, 0, 32'h104, 32'h1111_2222, 4'h0, 0, 32'hDEAD_BEEF);

    setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle_a", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      setin(1, 1, 32'h200, 0, 4'h0, 1, 1, 32'h40 + 32'(4 * k), 32'hB0 + 32'(k), 4'hF);
      cyc("burst_dma", 1, 1, 0, 32'h40 + 32'(4 * k), 32'hB0 + 32'(k), 4'hF, 0, 0);
    end
    setin(1, 1, 32'h200, 0, 4'h0, 1, 1, 32'h50, 32'hB4, 4'hF);
    cyc("burst_cpu_slot", 0, 0, 0, 32'h200, 0, 4'h0, 32'h1234_5678, 0);
    setin(1, 0, 0, 0, 0, 1, 1, 32'h50, 32'hB4, 4'hF);
    cyc("burst_dma_resume", 0, 1, 0, 32'h50, 32'hB4, 4'hF, 0, 0);

    setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle_b", 0, 0, 0, 0, 0, 0, 0, 0);
    setin(1, 0, 0, 0, 0, 1, 1, 32'h7F00, 32'h9999_9999, 4'hF);
    cyc("dma_err_wr", 0, 1, 1, 32'h7F00, 32'h9999_9999, 4'h0, 0, 0);
    memchk("mem_err_untouched", 32'h1FC0, 32'h55AA_55AA);
    setin(1, 1, 32'h200, 0, 4'h0, 1, 0, 32'h0, 0, 4'h0);
    cyc("after_err_dma", 1, 1, 0, 32'h0, 0, 4'h0, 0, 32'hD000_0000);

    setin(1, 1, 32'h200, 0, 4'h0, 1, 0, 32'h4, 0, 4'h0);
    cyc("pre_rst_dma", 1, 1, 0, 32'h4, 0, 4'h0, 0, 32'hD000_0001);
    setin(0, 1, 32'h200, 0, 4'h0, 1, 0, 32'h8, 0, 4'h0);
    cyc("mid_rst_a", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("mid_rst_b", 1, 0, 0, 0, 0, 0, 0, 0);
    setin(1, 1, 32'h200, 0, 4'h0, 1, 0, 32'h8, 0, 4'h0);
    cyc("post_rst_cpu", 0, 0, 0, 32'h200, 0, 4'h0, 32'h1234_5678, 0);
    setin(1, 1, 32'h0, 0, 4'h0, 1, 0, 32'h8, 0, 4'h0);
    cyc("post_rst_dma", 1, 1, 0, 32'h8, 0, 4'h0, 0, 32'hD000_0002);
    setin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle_end", 0, 0, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
